// File: rtl/univ_shift_reg.sv
// Multi-mode register: hold, parallel load, 1-bit shift/rotate and a counted burst rotate
// with a busy/done handshake. Synchronous reset and preset.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             preset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] q_reg;
  logic [CNT_W-1:0] count_reg;
  logic             sout_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             dir_reg;   // 0 = rotate left, 1 = rotate right

  always_ff @(posedge clk) begin
    done_reg <= 1'b0;
    if (reset) begin
      q_reg     <= '0;
      sout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      state_reg <= IDLE;
      count_reg <= '0;
      dir_reg   <= 1'b0;
    end else if (preset) begin
      // Aborts a burst silently; sout keeps its last value.
      q_reg     <= '1;
      busy_reg  <= 1'b0;
      state_reg <= IDLE;
    end else if (en) begin
      case (state_reg)
        IDLE: begin
          case (mode)
            3'b001: q_reg <= din;
            3'b010: begin
              q_reg    <= {q_reg[WIDTH-2:0], sin};
              sout_reg <= q_reg[WIDTH-1];
            end
            3'b011: begin
              q_reg    <= {sin, q_reg[WIDTH-1:1]};
              sout_reg <= q_reg[0];
            end
            3'b100: begin
              q_reg    <= {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
              sout_reg <= q_reg[WIDTH-1];
            end
            3'b101: begin
              q_reg    <= {q_reg[0], q_reg[WIDTH-1:1]};
              sout_reg <= q_reg[0];
            end
            3'b110, 3'b111: begin
              dir_reg   <= mode[0];
              count_reg <= shamt;
              if (shamt != '0) begin
                state_reg <= RUN;
                busy_reg  <= 1'b1;
              end else begin
                done_reg  <= 1'b1;
              end
            end
            default: ;
          endcase
        end
        RUN: begin
          if (dir_reg) begin
            q_reg    <= {q_reg[0], q_reg[WIDTH-1:1]};
            sout_reg <= q_reg[0];
          end else begin
            q_reg    <= {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
            sout_reg <= q_reg[WIDTH-1];
          end
          count_reg <= count_reg - 1'b1;
          // Last step: leave RUN and pulse done on the following cycle.
          if (count_reg == CNT_W'(1)) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_qbar
      assign qbar[gi] = ~q_reg[gi];
    end
  endgenerate

  assign q    = q_reg;
  assign sout = sout_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule
